soc_bus_xbar: RTL and testbench
===============================

// Module: soc_bus_xbar
// PURPOSE
// Parametrised NB_INIT x NB_TGT request/grant/response crossbar replacing the fixed 3x3 SoC node.
// Decodes per-target address windows. Arbitrates each target round-robin with request lock.
// Routes in-order responses back through per-target ID FIFOs. Answers unmapped accesses with an error.
// PARAMETERS
// NB_INIT     3             number of initiators (core, debug, SPI slave, ...)
// NB_TGT      3             number of targets (instr RAM, data RAM, peripherals, ...)
// ADDR_WIDTH  32            address width
// DATA_WIDTH  32            data width; BE width = DATA_WIDTH/8
// MAX_OUTST   2             per-target outstanding depth (ID FIFO depth, >=1)
// ERR_RDATA   32'hDEAD_BEEF rdata returned on decode error
// PORTS
// clk           in   1                    system clock
// rst           in   1                    async active-high reset
// start_addr_i  in   NB_TGT*ADDR_WIDTH    window base per target (inclusive), quasi-static
// end_addr_i    in   NB_TGT*ADDR_WIDTH    window end per target (inclusive), quasi-static
// init_req_i    in   NB_INIT              initiator request
// init_addr_i   in   NB_INIT*ADDR_WIDTH   request address
// init_we_i     in   NB_INIT              1 = write
// init_be_i     in   NB_INIT*DATA_WIDTH/8 byte enables
// init_wdata_i  in   NB_INIT*DATA_WIDTH   write data
// init_gnt_o    out  NB_INIT              request accepted this cycle
// init_rvalid_o out  NB_INIT              response valid (1 cycle)
// init_rdata_o  out  NB_INIT*DATA_WIDTH   read data
// init_err_o    out  NB_INIT              response error (target error or decode miss)
// tgt_req_o     out  NB_TGT               forwarded request
// tgt_addr_o / tgt_we_o / tgt_be_o / tgt_wdata_o  out  per target  forwarded payload
// tgt_gnt_i     in   NB_TGT               target accepts
// tgt_rvalid_i  in   NB_TGT               target response, in order, >=1 cycle after gnt
// tgt_rdata_i   in   NB_TGT*DATA_WIDTH    target read data
// tgt_err_i     in   NB_TGT               target error
// BEHAVIOUR
// - Reset: all outputs 0; RR pointers 0; locks, busy flags and ID FIFOs cleared.
// - Handshake: req held with stable payload until gnt. Transfer = req & gnt in the same cycle.
// - Decode (combinational): target t if start<=addr<=end; on overlap, lowest t wins. No hit -> error slot.
// - Initiator busy flag: set on gnt, cleared on its rvalid. While busy, its req is masked (one outstanding per initiator).
//   rvalid and a new gnt for the same initiator may coincide.
// - Arbiter per target: eligible = req & hit & !busy.
//   Winner = first eligible at or after the RR pointer. Pointer <= winner+1 (mod NB_INIT) only on transfer.
// - Lock: once tgt_req_o asserted without gnt, the selected initiator is held until transfer. No re-arbitration.
// - Payload mux is combinational. gnt path: tgt_gnt_i -> init_gnt_o is combinational (zero-cycle).
// - ID FIFO per target: push winner index on transfer. Pop on tgt_rvalid_i.
//   Response goes to init[head]: rvalid, rdata, err.
// - FIFO full masks tgt_req_o (no new request issued). Push and pop in the same cycle are allowed when full.
// - Decode miss: gnt in the request cycle (if not busy).
//   Next cycle: rvalid=1, err=1, rdata=ERR_RDATA. Multiple missing initiators are served round-robin, 1 per cycle.
// - Target rvalid with an empty FIFO: dropped; a simulation assertion fires.
// - Error response takes precedence over no target response. Target and error responses to the same initiator cannot collide.
// - Reset mid-operation clears all state. Target responses arriving after reset are dropped (FIFO empty).
// - Window config may change only when idle; results are undefined otherwise.
// STRUCTURE
// - soc_bus_xbar_pkg: idx_t (clog2 NB_INIT), req_t/rsp_t payload structs, ERR_RDATA default.
// - Sub-module soc_bus_xbar_rr_arb: eligible vector in, lock/RR state, one-hot grant out; one instance per target plus error slot.
// - ID FIFOs and busy flags are inline (generate loops).
// TESTING
// - Reset, single read: init0 reads 0x0010_0004, t1 gnt after 2 cycles, rvalid rdata=0x1234 -> init0 rvalid, rdata=0x1234, err=0.
// - Contention: init0/1/2 all request t2 every cycle with immediate gnt -> grants rotate 0,1,2,0; pointer unchanged while gnt=0.
// - Lock: init1 requests t0, gnt held low 5 cycles, init0 raises req meanwhile -> tgt_req_o stays on init1 payload until gnt.
// - Decode miss: init2 accesses 0x3000_0000 -> gnt same cycle; next cycle rvalid=1, err=1, rdata=0xDEAD_BEEF; no tgt_req_o.
// - Outstanding: MAX_OUTST=2, t0 delays rvalid; init0/1/2 request -> 2 grants, 3rd masked until first rvalid; responses in order.
// - Reset mid-transfer: assert rst with 2 pending -> outputs 0; later stray tgt_rvalid_i produces no init_rvalid_o.

Source files
------------

// File: rtl/soc_bus_xbar_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : soc_bus_xbar_pkg
//  Description : Shared defaults, index/payload types and helpers for the
//                NB_INIT x NB_TGT request/grant/response crossbar.
//  Revision    : 1.0 - initial release
// ============================================================================
package soc_bus_xbar_pkg;

   localparam int unsigned DEF_NB_INIT    = 3;
   localparam int unsigned DEF_NB_TGT     = 3;
   localparam int unsigned DEF_ADDR_WIDTH = 32;
   localparam int unsigned DEF_DATA_WIDTH = 32;
   localparam int unsigned DEF_MAX_OUTST  = 2;
   localparam logic [31:0] DEF_ERR_RDATA  = 32'hDEAD_BEEF;

   // Index width that stays legal (>=1 bit) for a single-entry range
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int unsigned DEF_IDX_W = idx_w(DEF_NB_INIT);

   typedef logic [DEF_IDX_W-1:0] idx_t;

   typedef struct packed {
      logic [DEF_ADDR_WIDTH-1:0]   addr;
      logic                        we;
      logic [DEF_DATA_WIDTH/8-1:0] be;
      logic [DEF_DATA_WIDTH-1:0]   wdata;
   } req_t;

   typedef struct packed {
      logic [DEF_DATA_WIDTH-1:0] rdata;
      logic                      err;
   } rsp_t;

endpackage
`default_nettype wire

// File: rtl/soc_bus_xbar_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : soc_bus_xbar_rr_arb
//  Description : Round-robin arbiter with request lock. The pointer moves
//                past the winner only on an accepted transfer; an issued but
//                unaccepted request freezes the selection until accepted.
//  Revision    : 1.0 - initial release
// ============================================================================
module soc_bus_xbar_rr_arb
   import soc_bus_xbar_pkg::*;
#(
   parameter  int unsigned N  = 3,
   localparam int unsigned IW = idx_w(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  elig_i,
   input  logic          issue_i,
   input  logic          accept_i,
   output logic [N-1:0]  gnt_oh_o,
   output logic [IW-1:0] gnt_idx_o,
   output logic          any_o
);

   logic [IW-1:0] ptr_q, ptr_d;
   logic [IW-1:0] lock_idx_q, lock_idx_d;
   logic          lock_q, lock_d;
   logic [IW-1:0] rr_idx;
   logic          rr_any;

   // Search downward so the first eligible at/after the pointer wins last
   always_comb begin
      rr_idx = ptr_q;
      rr_any = 1'b0;
      for (int k = N - 1; k >= 0; k--) begin
         if (elig_i[(int'(ptr_q) + k) % int'(N)]) begin
            rr_idx = IW'((int'(ptr_q) + k) % int'(N));
            rr_any = 1'b1;
         end
      end
   end

   // A held lock overrides the round-robin choice
   always_comb begin
      gnt_idx_o = lock_q ? lock_idx_q : rr_idx;
      any_o     = lock_q | rr_any;
      gnt_oh_o  = '0;
      if (any_o) begin
         gnt_oh_o[gnt_idx_o] = 1'b1;
      end
   end

   // Advance pointer on transfer, lock on an issued but stalled request
   always_comb begin
      ptr_d      = ptr_q;
      lock_d     = lock_q;
      lock_idx_d = lock_idx_q;
      if (accept_i) begin
         ptr_d  = (gnt_idx_o == IW'(N - 1)) ? '0 : gnt_idx_o + 1'b1;
         lock_d = 1'b0;
      end else if (issue_i) begin
         lock_d     = 1'b1;
         lock_idx_d = gnt_idx_o;
      end
   end

   // Arbiter state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q      <= '0;
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
      end else begin
         ptr_q      <= ptr_d;
         lock_q     <= lock_d;
         lock_idx_q <= lock_idx_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/soc_bus_xbar.sv
`default_nettype none
// ============================================================================
//  Module      : soc_bus_xbar
//  Description : NB_INIT x NB_TGT crossbar. Address-window decode, per-target
//                locked round-robin arbitration, in-order response return via
//                per-target ID FIFOs, and an error slot for unmapped accesses.
//  Revision    : 1.0 - initial release
// ============================================================================
module soc_bus_xbar
   import soc_bus_xbar_pkg::*;
#(
   parameter int unsigned           NB_INIT    = DEF_NB_INIT,
   parameter int unsigned           NB_TGT     = DEF_NB_TGT,
   parameter int unsigned           ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int unsigned           DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned           MAX_OUTST  = DEF_MAX_OUTST,
   parameter logic [DATA_WIDTH-1:0] ERR_RDATA  = DATA_WIDTH'(DEF_ERR_RDATA)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NB_TGT*ADDR_WIDTH-1:0]   start_addr_i,
   input  logic [NB_TGT*ADDR_WIDTH-1:0]   end_addr_i,
   input  logic [NB_INIT-1:0]             init_req_i,
   input  logic [NB_INIT*ADDR_WIDTH-1:0]  init_addr_i,
   input  logic [NB_INIT-1:0]             init_we_i,
   input  logic [NB_INIT*(DATA_WIDTH/8)-1:0] init_be_i,
   input  logic [NB_INIT*DATA_WIDTH-1:0]  init_wdata_i,
   output logic [NB_INIT-1:0]             init_gnt_o,
   output logic [NB_INIT-1:0]             init_rvalid_o,
   output logic [NB_INIT*DATA_WIDTH-1:0]  init_rdata_o,
   output logic [NB_INIT-1:0]             init_err_o,
   output logic [NB_TGT-1:0]              tgt_req_o,
   output logic [NB_TGT*ADDR_WIDTH-1:0]   tgt_addr_o,
   output logic [NB_TGT-1:0]              tgt_we_o,
   output logic [NB_TGT*(DATA_WIDTH/8)-1:0] tgt_be_o,
   output logic [NB_TGT*DATA_WIDTH-1:0]   tgt_wdata_o,
   input  logic [NB_TGT-1:0]              tgt_gnt_i,
   input  logic [NB_TGT-1:0]              tgt_rvalid_i,
   input  logic [NB_TGT*DATA_WIDTH-1:0]   tgt_rdata_i,
   input  logic [NB_TGT-1:0]              tgt_err_i
);

   localparam int unsigned IW = idx_w(NB_INIT);
   localparam int unsigned BW = DATA_WIDTH / 8;
   localparam int unsigned PW = idx_w(MAX_OUTST);
   localparam int unsigned CW = $clog2(MAX_OUTST + 1);

   logic [NB_TGT-1:0][NB_INIT-1:0] route;
   logic [NB_TGT-1:0][NB_INIT-1:0] elig;
   logic [NB_TGT-1:0][NB_INIT-1:0] win_oh;
   logic [NB_TGT-1:0][IW-1:0]      win_idx;
   logic [NB_TGT-1:0][IW-1:0]      head_idx;
   logic [NB_TGT-1:0]              win_any;
   logic [NB_TGT-1:0]              tgt_issue;
   logic [NB_TGT-1:0]              tgt_xfer;
   logic [NB_TGT-1:0]              pop;
   logic [NB_TGT-1:0]              fifo_empty;
   logic [NB_TGT-1:0]              fifo_full;
   logic [NB_INIT-1:0]             miss;
   logic [NB_INIT-1:0]             err_elig;
   logic [NB_INIT-1:0]             err_oh;
   logic [IW-1:0]                  err_idx;
   logic                           err_any;
   logic [NB_INIT-1:0]             busy_q, busy_d, busy_eff;
   logic                           err_vld_q, err_vld_d;
   logic [IW-1:0]                  err_idx_q, err_idx_d;
   logic                           dec_found;

   // Window decode; lowest matching target wins an overlap
   always_comb begin
      route     = '0;
      miss      = '0;
      dec_found = 1'b0;
      for (int i = 0; i < NB_INIT; i++) begin
         dec_found = 1'b0;
         for (int t = 0; t < NB_TGT; t++) begin
            if (!dec_found &&
                init_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH] >= start_addr_i[t*ADDR_WIDTH +: ADDR_WIDTH] &&
                init_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH] <= end_addr_i[t*ADDR_WIDTH +: ADDR_WIDTH]) begin
               route[t][i] = 1'b1;
               dec_found   = 1'b1;
            end
         end
         miss[i] = !dec_found;
      end
   end

   // Responses: target pops by FIFO head, plus the registered error slot
   always_comb begin
      init_rvalid_o = '0;
      init_err_o    = '0;
      init_rdata_o  = '0;
      for (int t = 0; t < NB_TGT; t++) begin
         if (pop[t]) begin
            init_rvalid_o[head_idx[t]] = 1'b1;
            init_err_o[head_idx[t]]    = tgt_err_i[t];
            init_rdata_o[head_idx[t]*DATA_WIDTH +: DATA_WIDTH] = tgt_rdata_i[t*DATA_WIDTH +: DATA_WIDTH];
         end
      end
      if (err_vld_q) begin
         init_rvalid_o[err_idx_q] = 1'b1;
         init_err_o[err_idx_q]    = 1'b1;
         init_rdata_o[err_idx_q*DATA_WIDTH +: DATA_WIDTH] = ERR_RDATA;
      end
   end

   // A response this cycle frees the initiator for a back-to-back grant
   assign busy_eff = busy_q & ~init_rvalid_o;

   // Per-target and error-slot eligibility
   always_comb begin
      for (int t = 0; t < NB_TGT; t++) begin
         elig[t] = init_req_i & route[t] & ~busy_eff;
      end
      err_elig = init_req_i & miss & ~busy_eff;
   end

   // Grants: accepted target transfers plus the always-ready error slot
   always_comb begin
      init_gnt_o = err_oh;
      for (int t = 0; t < NB_TGT; t++) begin
         if (tgt_xfer[t]) begin
            init_gnt_o = init_gnt_o | win_oh[t];
         end
      end
   end

   // Payload mux from the selected initiator; zero when nothing selected
   always_comb begin
      tgt_addr_o  = '0;
      tgt_we_o    = '0;
      tgt_be_o    = '0;
      tgt_wdata_o = '0;
      for (int t = 0; t < NB_TGT; t++) begin
         if (win_any[t]) begin
            tgt_addr_o[t*ADDR_WIDTH +: ADDR_WIDTH]  = init_addr_i[win_idx[t]*ADDR_WIDTH +: ADDR_WIDTH];
            tgt_we_o[t]                             = init_we_i[win_idx[t]];
            tgt_be_o[t*BW +: BW]                    = init_be_i[win_idx[t]*BW +: BW];
            tgt_wdata_o[t*DATA_WIDTH +: DATA_WIDTH] = init_wdata_i[win_idx[t]*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign tgt_req_o = tgt_issue;

   // Busy tracking and the one-cycle-delayed error response
   always_comb begin
      busy_d    = (busy_q & ~init_rvalid_o) | init_gnt_o;
      err_vld_d = err_any;
      err_idx_d = err_idx;
   end

   // Initiator busy flags and error slot registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q    <= '0;
         err_vld_q <= 1'b0;
         err_idx_q <= '0;
      end else begin
         busy_q    <= busy_d;
         err_vld_q <= err_vld_d;
         err_idx_q <= err_idx_d;
      end
   end

   // Error slot arbiter: every selection is accepted in the same cycle
   soc_bus_xbar_rr_arb #(
      .N (NB_INIT)
   ) u_err_arb (
      .clk       (clk),
      .rst       (rst),
      .elig_i    (err_elig),
      .issue_i   (err_any),
      .accept_i  (err_any),
      .gnt_oh_o  (err_oh),
      .gnt_idx_o (err_idx),
      .any_o     (err_any)
   );

   for (genvar t = 0; t < NB_TGT; t++) begin : g_tgt
      logic [MAX_OUTST-1:0][IW-1:0] mem_q, mem_d;
      logic [PW-1:0]                wr_q, wr_d, rd_q, rd_d;
      logic [CW-1:0]                cnt_q, cnt_d;

      assign fifo_empty[t] = (cnt_q == '0);
      assign fifo_full[t]  = (cnt_q == CW'(MAX_OUTST));
      assign head_idx[t]   = mem_q[rd_q];
      assign pop[t]        = tgt_rvalid_i[t] & ~fifo_empty[t];
      // A full FIFO blocks issue unless an entry retires this same cycle
      assign tgt_issue[t]  = win_any[t] & (~fifo_full[t] | pop[t]);
      assign tgt_xfer[t]   = tgt_issue[t] & tgt_gnt_i[t];

      soc_bus_xbar_rr_arb #(
         .N (NB_INIT)
      ) u_arb (
         .clk       (clk),
         .rst       (rst),
         .elig_i    (elig[t]),
         .issue_i   (tgt_issue[t]),
         .accept_i  (tgt_xfer[t]),
         .gnt_oh_o  (win_oh[t]),
         .gnt_idx_o (win_idx[t]),
         .any_o     (win_any[t])
      );

      // ID FIFO: push winner on transfer, pop on target response
      always_comb begin
         mem_d = mem_q;
         wr_d  = wr_q;
         rd_d  = rd_q;
         cnt_d = cnt_q;
         if (tgt_xfer[t]) begin
            mem_d[wr_q] = win_idx[t];
            wr_d        = (wr_q == PW'(MAX_OUTST - 1)) ? '0 : wr_q + 1'b1;
         end
         if (pop[t]) begin
            rd_d = (rd_q == PW'(MAX_OUTST - 1)) ? '0 : rd_q + 1'b1;
         end
         case ({tgt_xfer[t], pop[t]})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
         endcase
      end

      // ID FIFO storage and pointers
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            mem_q <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
         end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
         end
      end

      // A target response with nothing outstanding is dropped
      a_no_stray_rsp : assert property (@(posedge clk) disable iff (rst)
         !(tgt_rvalid_i[t] && fifo_empty[t]));
   end

endmodule
`default_nettype wire

// File: tb/tb_soc_bus_xbar.sv
`default_nettype none
// ============================================================================
//  Module      : tb_soc_bus_xbar
//  Description : Directed self-checking bench for the 3x3 crossbar.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_soc_bus_xbar;

   localparam int NI = 3;
   localparam int NT = 3;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int BW = DW / 8;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NT*AW-1:0]  start_addr;
   logic [NT*AW-1:0]  end_addr;
   logic [NI-1:0]     init_req = '0;
   logic [NI*AW-1:0]  init_addr = '0;
   logic [NI-1:0]     init_we = '0;
   logic [NI*BW-1:0]  init_be = '0;
   logic [NI*DW-1:0]  init_wdata = '0;
   logic [NI-1:0]     init_gnt;
   logic [NI-1:0]     init_rvalid;
   logic [NI*DW-1:0]  init_rdata;
   logic [NI-1:0]     init_err;
   logic [NT-1:0]     tgt_req;
   logic [NT*AW-1:0]  tgt_addr;
   logic [NT-1:0]     tgt_we;
   logic [NT*BW-1:0]  tgt_be;
   logic [NT*DW-1:0]  tgt_wdata;
   logic [NT-1:0]     tgt_gnt = '0;
   logic [NT-1:0]     tgt_rvalid = '0;
   logic [NT*DW-1:0]  tgt_rdata = '0;
   logic [NT-1:0]     tgt_err = '0;

   int n_chk = 0;
   int n_err = 0;

   assign start_addr = {32'h2000_0000, 32'h0010_0000, 32'h0000_0000};
   assign end_addr   = {32'h2FFF_FFFF, 32'h001F_FFFF, 32'h000F_FFFF};

   always #5 clk = ~clk;

   soc_bus_xbar dut (
      .clk           (clk),
      .rst           (rst),
      .start_addr_i  (start_addr),
      .end_addr_i    (end_addr),
      .init_req_i    (init_req),
      .init_addr_i   (init_addr),
      .init_we_i     (init_we),
      .init_be_i     (init_be),
      .init_wdata_i  (init_wdata),
      .init_gnt_o    (init_gnt),
      .init_rvalid_o (init_rvalid),
      .init_rdata_o  (init_rdata),
      .init_err_o    (init_err),
      .tgt_req_o     (tgt_req),
      .tgt_addr_o    (tgt_addr),
      .tgt_we_o      (tgt_we),
      .tgt_be_o      (tgt_be),
      .tgt_wdata_o   (tgt_wdata),
      .tgt_gnt_i     (tgt_gnt),
      .tgt_rvalid_i  (tgt_rvalid),
      .tgt_rdata_i   (tgt_rdata),
      .tgt_err_i     (tgt_err)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [31:0] a, input logic we, input logic [31:0] wd);
      init_req[i]            = 1'b1;
      init_addr[i*AW +: AW]  = a;
      init_we[i]             = we;
      init_be[i*BW +: BW]    = 4'hF;
      init_wdata[i*DW +: DW] = wd;
   endtask

   task automatic set_rsp(input int t, input logic [31:0] rd, input logic e);
      tgt_rvalid[t]         = 1'b1;
      tgt_rdata[t*DW +: DW] = rd;
      tgt_err[t]            = e;
   endtask

   initial begin
      // Reset state
      #12;
      chk("rst_gnt",    64'(init_gnt),    64'h0);
      chk("rst_rvalid", 64'(init_rvalid), 64'h0);
      chk("rst_rdata",  64'(init_rdata),  64'h0);
      chk("rst_err",    64'(init_err),    64'h0);
      chk("rst_treq",   64'(tgt_req),     64'h0);
      chk("rst_taddr",  64'(tgt_addr),    64'h0);
      cyc();
      rst = 1'b0;
      cyc();

      // Single read to t1 with a 2-cycle gnt delay
      set_req(0, 32'h0010_0004, 1'b0, 32'h0);
      #1;
      chk("sr_treq",  64'(tgt_req), 64'b010);
      chk("sr_taddr", 64'(tgt_addr[1*AW +: AW]), 64'h0010_0004);
      chk("sr_nognt", 64'(init_gnt), 64'b000);
      cyc();
      chk("sr_nognt2", 64'(init_gnt), 64'b000);
      cyc();
      tgt_gnt[1] = 1'b1;
      #1;
      chk("sr_gnt", 64'(init_gnt), 64'b001);
      cyc();
      init_req = '0;
      tgt_gnt  = '0;
      set_rsp(1, 32'h0000_1234, 1'b0);
      #1;
      chk("sr_rvalid", 64'(init_rvalid), 64'b001);
      chk("sr_rdata",  64'(init_rdata[0 +: DW]), 64'h1234);
      chk("sr_err",    64'(init_err), 64'b000);
      cyc();
      tgt_rvalid = '0;
      #1;
      chk("sr_idle", 64'(init_rvalid), 64'b000);

      // Contention on t2: grants rotate 0,1,2,0 then hold while gnt is low
      cyc();
      for (int i = 0; i < NI; i++) set_req(i, 32'h2000_0000 + 32'(i * 16), 1'b0, 32'h0);
      tgt_gnt[2] = 1'b1;
      #1;
      chk("rr_gntA", 64'(init_gnt), 64'b001);
      cyc();
      set_rsp(2, 32'h0, 1'b0);
      #1;
      chk("rr_gntB", 64'(init_gnt), 64'b010);
      chk("rr_rspB", 64'(init_rvalid), 64'b001);
      cyc();
      #1;
      chk("rr_gntC", 64'(init_gnt), 64'b100);
      chk("rr_rspC", 64'(init_rvalid), 64'b010);
      cyc();
      #1;
      chk("rr_gntD", 64'(init_gnt), 64'b001);
      chk("rr_rspD", 64'(init_rvalid), 64'b100);
      cyc();
      tgt_gnt[2] = 1'b0;
      #1;
      chk("rr_gntE",  64'(init_gnt), 64'b000);
      chk("rr_rspE",  64'(init_rvalid), 64'b001);
      chk("rr_addrE", 64'(tgt_addr[2*AW +: AW]), 64'h2000_0010);
      cyc();
      tgt_rvalid = '0;
      #1;
      chk("rr_addrF", 64'(tgt_addr[2*AW +: AW]), 64'h2000_0010);
      cyc();
      tgt_gnt[2] = 1'b1;
      #1;
      chk("rr_gntG", 64'(init_gnt), 64'b010);
      cyc();
      init_req = '0;
      tgt_gnt  = '0;
      set_rsp(2, 32'h0, 1'b0);
      #1;
      chk("rr_rspH", 64'(init_rvalid), 64'b010);
      cyc();
      tgt_rvalid = '0;

      // Lock on t0: init1 held through 5 stalled cycles despite init0
      set_req(1, 32'h0000_0100, 1'b1, 32'hAAAA_0001);
      #1;
      chk("lk_addr0", 64'(tgt_addr[0 +: AW]), 64'h0000_0100);
      for (int c = 1; c < 5; c++) begin
         cyc();
         set_req(0, 32'h0000_0200, 1'b0, 32'h0);
         #1;
         chk("lk_addr", 64'(tgt_addr[0 +: AW]), 64'h0000_0100);
         chk("lk_wdata", 64'(tgt_wdata[0 +: DW]), 64'hAAAA_0001);
      end
      chk("lk_we", 64'(tgt_we), 64'b001);
      cyc();
      tgt_gnt[0] = 1'b1;
      #1;
      chk("lk_gnt1", 64'(init_gnt), 64'b010);
      cyc();
      init_req[1] = 1'b0;
      #1;
      chk("lk_gnt0",  64'(init_gnt), 64'b001);
      chk("lk_addr2", 64'(tgt_addr[0 +: AW]), 64'h0000_0200);
      cyc();
      init_req = '0;
      tgt_gnt  = '0;
      set_rsp(0, 32'h0000_0077, 1'b0);
      #1;
      chk("lk_rsp1",  64'(init_rvalid), 64'b010);
      chk("lk_rdat1", 64'(init_rdata[1*DW +: DW]), 64'h77);
      cyc();
      #1;
      chk("lk_rsp0", 64'(init_rvalid), 64'b001);
      cyc();
      tgt_rvalid = '0;

      // Decode miss from init2
      set_req(2, 32'h3000_0000, 1'b0, 32'h0);
      #1;
      chk("dm_gnt",  64'(init_gnt), 64'b100);
      chk("dm_treq", 64'(tgt_req),  64'b000);
      cyc();
      init_req = '0;
      #1;
      chk("dm_rvalid", 64'(init_rvalid), 64'b100);
      chk("dm_err",    64'(init_err),    64'b100);
      chk("dm_rdata",  64'(init_rdata[2*DW +: DW]), 64'hDEAD_BEEF);
      cyc();
      #1;
      chk("dm_idle", 64'(init_rvalid | init_err), 64'b000);

      // Outstanding limit on t0 (pointer now at 1)
      for (int i = 0; i < NI; i++) set_req(i, 32'h0000_0010 + 32'(i * 16), 1'b0, 32'h0);
      tgt_gnt[0] = 1'b1;
      #1;
      chk("os_gntA", 64'(init_gnt), 64'b010);
      cyc();
      init_req[1] = 1'b0;
      #1;
      chk("os_gntB", 64'(init_gnt), 64'b100);
      cyc();
      init_req[2] = 1'b0;
      #1;
      chk("os_fullC", 64'(tgt_req), 64'b000);
      chk("os_gntC",  64'(init_gnt), 64'b000);
      cyc();
      #1;
      chk("os_fullD", 64'(init_gnt), 64'b000);
      cyc();
      set_rsp(0, 32'h0000_0055, 1'b0);
      #1;
      chk("os_rspE",  64'(init_rvalid), 64'b010);
      chk("os_datE",  64'(init_rdata[1*DW +: DW]), 64'h55);
      chk("os_gntE",  64'(init_gnt), 64'b001);
      cyc();
      init_req = '0;
      tgt_gnt  = '0;
      set_rsp(0, 32'h0000_0066, 1'b1);
      #1;
      chk("os_rspF", 64'(init_rvalid), 64'b100);
      chk("os_datF", 64'(init_rdata[2*DW +: DW]), 64'h66);
      chk("os_errF", 64'(init_err), 64'b100);
      cyc();
      set_rsp(0, 32'h0000_0088, 1'b0);
      #1;
      chk("os_rspG", 64'(init_rvalid), 64'b001);
      chk("os_datG", 64'(init_rdata[0 +: DW]), 64'h88);
      cyc();
      tgt_rvalid = '0;
      tgt_err    = '0;

      // Reset with two transfers pending
      set_req(0, 32'h0010_0000, 1'b0, 32'h0);
      set_req(1, 32'h2000_0000, 1'b0, 32'h0);
      tgt_gnt = 3'b110;
      #1;
      chk("mr_gnt", 64'(init_gnt), 64'b011);
      cyc();
      init_req = '0;
      tgt_gnt  = '0;
      rst      = 1'b1;
      #1;
      chk("mr_rvalid", 64'(init_rvalid), 64'b000);
      chk("mr_treq",   64'(tgt_req),     64'b000);
      set_rsp(1, 32'h0000_0BAD, 1'b0);
      set_rsp(2, 32'h0000_0BAD, 1'b0);
      #1;
      chk("mr_stray", 64'(init_rvalid), 64'b000);
      cyc();
      tgt_rvalid = '0;
      rst        = 1'b0;
      #1;
      chk("mr_post", 64'(init_rvalid), 64'b000);
      cyc();
      set_req(0, 32'h0010_0000, 1'b0, 32'h0);
      tgt_gnt[1] = 1'b1;
      #1;
      chk("mr_regnt", 64'(init_gnt), 64'b001);
      cyc();
      init_req = '0;
      tgt_gnt  = '0;
      set_rsp(1, 32'h0000_0ABC, 1'b0);
      #1;
      chk("mr_rsp", 64'(init_rvalid), 64'b001);
      cyc();
      tgt_rvalid = '0;
      cyc();

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
`default_nettype wire
